// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshakes plus transmitter launch/complete strobes for uart_tx_arbiter.
// master = requesters and transmitter side, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic [GW-1:0]        grant_id;
  logic                 locked;

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_en, tx_data, grant_id, locked
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_en, tx_data, grant_id, locked
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte streams,
// with a per-packet grant lock that is dropped after LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd50000
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] ARB       = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]         state_reg, state_next;
  logic [GW-1:0]      grant_reg, grant_next;
  logic [GW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic               locked_reg, locked_next;
  logic               last_reg, last_next;
  logic [15:0]        lock_cnt_reg, lock_cnt_next;
  logic [GW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_valid;
  logic [NUM_REQ-1:0] ready_vec;
  logic               found;
  logic [GW-1:0]      found_idx;
  logic [GW-1:0]      grant_inc;
  logic               launch;

  assign launch    = (state_reg == LAUNCH);
  assign grant_inc = (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + GW'(1);

  // cand_idx[k] is the k-th requester visited when searching from rr_ptr
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign cand_idx[gi]   = GW'((int'(rr_ptr_reg) + gi) % NUM_REQ);
      assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
      assign ready_vec[gi]  = launch && (grant_reg == GW'(gi));
    end
  endgenerate

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_valid[i]) begin
        found     = 1'b1;
        found_idx = cand_idx[i];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    locked_next   = locked_reg;
    last_next     = last_reg;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      ARB: begin
        if (locked_reg) begin
          // A valid from the lock holder always beats a timeout in the same cycle
          if (bus.req_valid[grant_reg]) begin
            if (!bus.tx_busy) state_next = LAUNCH;
          end else if (lock_cnt_reg == LOCK_TIMEOUT - 16'd1) begin
            locked_next   = 1'b0;
            rr_ptr_next   = grant_inc;
            lock_cnt_next = '0;
          end else begin
            lock_cnt_next = lock_cnt_reg + 16'd1;
          end
        end else if (!bus.tx_busy && found) begin
          grant_next = found_idx;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        last_next     = bus.req_last[grant_reg];
        lock_cnt_next = '0;
        state_next    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          locked_next = !last_reg;
          if (last_reg) rr_ptr_next = grant_inc;
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ARB;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      locked_reg   <= 1'b0;
      last_reg     <= 1'b0;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      locked_reg   <= locked_next;
      last_reg     <= last_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  assign bus.tx_en     = launch;
  assign bus.req_ready = ready_vec;
  assign bus.tx_data   = launch ? bus.req_data[{grant_reg, 3'b000} +: 8] : 8'h00;
  assign bus.grant_id  = grant_reg;
  assign bus.locked    = locked_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes, a transmitter
// model answers with tx_done, and a monitor pops expected (grant, byte) pairs on tx_en.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TX_LAT  = 3;

  logic clk;
  logic rst;
  logic busy_force;
  logic model_busy;
  logic model_done;
  int   tx_cnt;
  int   tests;
  int   fails;

  logic [8:0]  rq [NUM_REQ][$];
  logic [9:0]  exp_q [$];
  logic [3:0]  rdy_seen;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .LOCK_TIMEOUT(16'd20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.tx_busy = model_busy | busy_force;
  assign bus.tx_done = model_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic expect_tx(input logic [1:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic wait_tx(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_en && n < 200);
    if (!bus.tx_en) begin
      tests++;
      fails++;
      $display("FAIL %s: no tx_en within %0d cycles", name, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int  n;
    logic pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 3000) begin
      @(negedge clk);
      n++;
      pend = (exp_q.size() != 0) || model_busy;
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) pend = 1'b1;
    end
    if (pend) begin
      tests++;
      fails++;
      $display("FAIL %s: traffic did not drain, %0d expected bytes left", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requesters: present queue heads after each edge, pop when accepted last cycle
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rdy_seen[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          bus.req_valid[i]        = 1'b1;
          bus.req_data[8*i +: 8]  = rq[i][0][7:0];
          bus.req_last[i]         = rq[i][0][8];
        end else begin
          bus.req_valid[i]        = 1'b0;
          bus.req_data[8*i +: 8]  = 8'h00;
          bus.req_last[i]         = 1'b0;
        end
      end
    end
  end

  initial begin
    rdy_seen = '0;
    forever begin
      @(negedge clk);
      rdy_seen = bus.req_ready;
    end
  end

  // Transmitter: busy for TX_LAT cycles after tx_en, then a one-cycle tx_done
  initial begin
    model_busy = 1'b0;
    model_done = 1'b0;
    tx_cnt     = 0;
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          model_done = 1'b1;
          model_busy = 1'b0;
        end
      end
      if (bus.tx_en) begin
        tx_cnt     = TX_LAT;
        model_busy = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [9:0] e;
    logic [3:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (bus.tx_en) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: tx_en grant %0d data %02h, nothing expected", bus.grant_id, bus.tx_data);
        end else begin
          e       = exp_q.pop_front();
          exp_rdy = 4'b0001 << e[9:8];
          $display("[TB] tx grant=%0d data=%02h ready=%b", bus.grant_id, bus.tx_data, bus.req_ready);
          check("sb_grant", 32'(bus.grant_id), 32'(e[9:8]));
          check("sb_data", 32'(bus.tx_data), 32'(e[7:0]));
          check("sb_ready", 32'(bus.req_ready), 32'(exp_rdy));
        end
      end else begin
        check("ready_without_en", 32'(bus.req_ready), 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw_en;
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    busy_force = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_en", 32'(bus.tx_en), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_grant", 32'(bus.grant_id), 32'h0);
    check("rst_locked", 32'(bus.locked), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    rst = 1'b0;

    // Single-byte packets from requester 2, plus back-to-back spacing
    expect_tx(2'd2, 8'hA5);
    expect_tx(2'd2, 8'hA6);
    push_req(2, 8'hA5, 1'b1);
    push_req(2, 8'hA6, 1'b1);
    @(negedge clk);
    check("t1_no_early_en", 32'(bus.tx_en), 32'h0);
    @(negedge clk);
    check("t1_launch_en", 32'(bus.tx_en), 32'h1);
    check("t1_ready", 32'(bus.req_ready), 32'h4);
    check("t1_data", 32'(bus.tx_data), 32'hA5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_en && n < 50);
    check("t1_b2b_gap", 32'(n), 32'd5);
    wait_drain("t1_drain");
    check("t1_locked", 32'(bus.locked), 32'h0);

    // rr_ptr is now 3: requester 3 must beat requester 0
    expect_tx(2'd3, 8'h3F);
    expect_tx(2'd0, 8'h0F);
    push_req(0, 8'h0F, 1'b1);
    push_req(3, 8'h3F, 1'b1);
    wait_drain("t1b_drain");

    // Round-robin over 0, 1, 3 from reset
    do_reset(2);
    expect_tx(2'd0, 8'h01);
    expect_tx(2'd1, 8'h11);
    expect_tx(2'd3, 8'h31);
    expect_tx(2'd0, 8'h02);
    expect_tx(2'd1, 8'h12);
    expect_tx(2'd3, 8'h32);
    push_req(0, 8'h01, 1'b1);
    push_req(0, 8'h02, 1'b1);
    push_req(1, 8'h11, 1'b1);
    push_req(1, 8'h12, 1'b1);
    push_req(3, 8'h31, 1'b1);
    push_req(3, 8'h32, 1'b1);
    wait_drain("t2_drain");

    // Packet lock: 3-byte packet from requester 1, requester 0 waiting
    expect_tx(2'd1, 8'h11);
    expect_tx(2'd1, 8'h22);
    expect_tx(2'd1, 8'h33);
    expect_tx(2'd0, 8'hAA);
    push_req(1, 8'h11, 1'b0);
    push_req(1, 8'h22, 1'b0);
    push_req(1, 8'h33, 1'b1);
    @(negedge clk);
    push_req(0, 8'hAA, 1'b1);
    wait_tx("t3_b1");
    check("t3_locked_b1", 32'(bus.locked), 32'h0);
    wait_tx("t3_b2");
    check("t3_locked_b2", 32'(bus.locked), 32'h1);
    wait_tx("t3_b3");
    check("t3_locked_b3", 32'(bus.locked), 32'h1);
    wait_tx("t3_b4");
    check("t3_next_grant", 32'(bus.grant_id), 32'h0);
    check("t3_locked_b4", 32'(bus.locked), 32'h0);
    wait_drain("t3_drain");

    // Lock timeout: requester 0 leaves the packet open, requester 2 waits
    expect_tx(2'd0, 8'h50);
    expect_tx(2'd2, 8'h52);
    push_req(0, 8'h50, 1'b0);
    wait_tx("t4_b1");
    push_req(2, 8'h52, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_done && n < 50);
    repeat (20) @(negedge clk);
    check("t4_locked_last_idle", 32'(bus.locked), 32'h1);
    @(negedge clk);
    check("t4_lock_dropped", 32'(bus.locked), 32'h0);
    @(negedge clk);
    check("t4_grant_en", 32'(bus.tx_en), 32'h1);
    check("t4_grant_id", 32'(bus.grant_id), 32'h2);
    wait_drain("t4_drain");

    // Busy gating
    busy_force = 1'b1;
    expect_tx(2'd3, 8'h77);
    push_req(3, 8'h77, 1'b1);
    saw_en = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.tx_en) saw_en = 1'b1;
    end
    check("t5_no_en_while_busy", 32'(saw_en), 32'h0);
    busy_force = 1'b0;
    @(negedge clk);
    check("t5_en_after_release", 32'(bus.tx_en), 32'h1);
    check("t5_ready", 32'(bus.req_ready), 32'h8);
    wait_drain("t5_drain");

    // Reset during WAIT_DONE of a locked packet
    expect_tx(2'd1, 8'h61);
    expect_tx(2'd1, 8'h62);
    expect_tx(2'd0, 8'h80);
    expect_tx(2'd2, 8'h92);
    push_req(1, 8'h61, 1'b0);
    push_req(1, 8'h62, 1'b1);
    wait_tx("t6_b1");
    push_req(0, 8'h80, 1'b1);
    push_req(2, 8'h92, 1'b1);
    wait_tx("t6_b2");
    check("t6_locked_b2", 32'(bus.locked), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_tx_en", 32'(bus.tx_en), 32'h0);
    check("t6_rst_ready", 32'(bus.req_ready), 32'h0);
    check("t6_rst_grant", 32'(bus.grant_id), 32'h0);
    check("t6_rst_locked", 32'(bus.locked), 32'h0);
    check("t6_rst_tx_data", 32'(bus.tx_data), 32'h0);
    rst = 1'b0;
    wait_tx("t6_post_rst");
    check("t6_post_grant", 32'(bus.grant_id), 32'h0);
    check("t6_post_locked", 32'(bus.locked), 32'h0);
    wait_drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
